fpu_sched: RTL and testbench

//  Shares one combinational FPU between N requesters (shader lanes, raster setup) with round-robin arbitration.

---
 rtl/fpu_pkg.sv | 32 +++
 rtl/fpu_rsp_fifo.sv | 50 +++++
 rtl/fpu_sched.sv | 162 ++++++++++++++++
 tb/tb_fpu_sched.sv | 374 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fpu_pkg.sv
// Shared types for the FPU scheduler: opcodes, datapath width and the
// response record carried through the response FIFO.
package fpu_pkg;

   localparam int FP_W     = 32;
   // Wide enough for any practical requester count; the top uses the low bits.
   localparam int RSP_ID_W = 8;

   typedef enum logic [2:0] {
      FP_ADD = 3'b000,
      FP_SUB = 3'b001,
      FP_MUL = 3'b010,
      FP_MAX = 3'b011,
      FP_MIN = 3'b100,
      FP_ABS = 3'b101,
      FP_NEG = 3'b110
   } fpu_op_e;

   // The one encoding the FPU does not implement.
   localparam logic [2:0] FP_ILLEGAL = 3'b111;

   typedef struct packed {
      logic [RSP_ID_W-1:0] id;
      logic [FP_W-1:0]     result;
      logic                err;
   } fpu_rsp_t;

   function automatic logic is_illegal_op(input logic [2:0] op);
      return op == FP_ILLEGAL;
   endfunction

endpackage

// File: rtl/fpu_rsp_fifo.sv
// Response FIFO for the FPU scheduler. Pointers carry an extra wrap bit so
// full and empty are distinguished without a separate flag. The scheduler's
// credit check guarantees a push never arrives while the FIFO is full.
module fpu_rsp_fifo
   import fpu_pkg::*;
#(
   parameter  int DEPTH = 4,
   localparam int AW    = $clog2(DEPTH)
) (
   input  logic          clk_i,
   input  logic          rst_i,
   input  logic          push_i,
   input  fpu_rsp_t      push_data_i,
   input  logic          pop_i,
   output logic          valid_o,
   output fpu_rsp_t      head_o,
   output logic [AW:0]   count_o
);

   logic [AW:0] wr_ptr;
   logic [AW:0] rd_ptr;
   fpu_rsp_t    mem [DEPTH];

   // Advance write/read pointers; pops on an empty FIFO are ignored.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push_i) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop_i && valid_o) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
      end
   end

   // Storage has no reset: an entry is only read after it has been written.
   always_ff @(posedge clk_i) begin
      if (push_i) begin
         mem[wr_ptr[AW-1:0]] <= push_data_i;
      end
   end

   assign count_o = wr_ptr - rd_ptr;
   assign valid_o = (count_o != '0);
   assign head_o  = mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/fpu_sched.sv
// Round-robin scheduler sharing one combinational FPU between N_REQ
// requesters. Operands are registered towards the FPU, the result is sampled
// FPU_LAT cycles later and queued in a credit-protected response FIFO that is
// returned on one valid/ready channel tagged with the requester index.
module fpu_sched
   import fpu_pkg::*;
#(
   parameter  int N_REQ     = 4,
   parameter  int FPU_LAT   = 1,
   parameter  int RSP_DEPTH = 4,
   localparam int ID_W      = $clog2(N_REQ)
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic [N_REQ-1:0]      req_valid_i,
   output logic [N_REQ-1:0]      req_ready_o,
   input  logic [3*N_REQ-1:0]    req_op_i,
   input  logic [FP_W*N_REQ-1:0] req_a_i,
   input  logic [FP_W*N_REQ-1:0] req_b_i,
   output logic [FP_W-1:0]       fpu_a_o,
   output logic [FP_W-1:0]       fpu_b_o,
   output logic [2:0]            fpu_ctrl_o,
   input  logic [FP_W-1:0]       fpu_result_i,
   output logic                  rsp_valid_o,
   input  logic                  rsp_ready_i,
   output logic [ID_W-1:0]       rsp_id_o,
   output logic [FP_W-1:0]       rsp_result_o,
   output logic                  rsp_err_o,
   output logic                  busy_o
);

   // Wide enough to hold FIFO occupancy plus every pipe stage.
   localparam int CNT_W  = $clog2(RSP_DEPTH + FPU_LAT + 1);
   localparam int FIFO_W = $clog2(RSP_DEPTH) + 1;

   logic [ID_W-1:0]    ptr;
   logic [ID_W-1:0]    grant_idx;
   logic               grant_found;
   logic               credit;
   logic               handshake;
   logic [CNT_W-1:0]   inflight;
   logic [CNT_W-1:0]   occupancy;
   logic [FIFO_W-1:0]  fifo_count;

   logic [2:0]         sel_op;
   logic [FP_W-1:0]    sel_a;
   logic [FP_W-1:0]    sel_b;

   logic [FPU_LAT-1:0] pipe_valid;
   logic [FPU_LAT-1:0] pipe_err;
   logic [ID_W-1:0]    pipe_id [FPU_LAT];

   fpu_rsp_t           push_data;
   fpu_rsp_t           head;
   logic               push;
   logic               pop;
   logic               fifo_valid;
   logic               unused_head_id;

   // Credit: every op already issued (in the pipe or queued) owns a FIFO slot.
   // Only registered state is used, so a pop in this cycle frees nothing yet.
   always_comb begin
      inflight = '0;
      for (int s = 0; s < FPU_LAT; s++) begin
         inflight = inflight + CNT_W'(pipe_valid[s]);
      end
      occupancy = inflight + CNT_W'(fifo_count);
      credit    = occupancy < CNT_W'(RSP_DEPTH);
   end

   // Round-robin pick: first valid requester at or after ptr, wrapping.
   always_comb begin
      grant_found = 1'b0;
      grant_idx   = '0;
      for (int i = 0; i < N_REQ; i++) begin
         if (!grant_found && req_valid_i[(int'(ptr) + i) % N_REQ]) begin
            grant_found = 1'b1;
            grant_idx   = ID_W'((int'(ptr) + i) % N_REQ);
         end
      end
   end

   // Accept signal and operand mux for the granted requester.
   always_comb begin
      handshake   = grant_found && credit;
      req_ready_o = '0;
      if (handshake) begin
         req_ready_o[grant_idx] = 1'b1;
      end
      sel_op = req_op_i[3*int'(grant_idx) +: 3];
      sel_a  = req_a_i[FP_W*int'(grant_idx) +: FP_W];
      sel_b  = req_b_i[FP_W*int'(grant_idx) +: FP_W];
   end

   // Issue: register operands to the FPU, move the pointer past the winner
   // and shift valid/id/err down the pipe that tracks the FPU latency.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         ptr        <= '0;
         fpu_a_o    <= '0;
         fpu_b_o    <= '0;
         fpu_ctrl_o <= '0;
         pipe_valid <= '0;
         pipe_err   <= '0;
         for (int s = 0; s < FPU_LAT; s++) begin
            pipe_id[s] <= '0;
         end
      end else begin
         if (handshake) begin
            fpu_a_o    <= sel_a;
            fpu_b_o    <= sel_b;
            fpu_ctrl_o <= sel_op;
            ptr        <= (grant_idx == ID_W'(N_REQ - 1)) ? '0 : grant_idx + 1'b1;
         end
         pipe_valid[0] <= handshake;
         pipe_err[0]   <= is_illegal_op(sel_op);
         pipe_id[0]    <= grant_idx;
         for (int s = 1; s < FPU_LAT; s++) begin
            pipe_valid[s] <= pipe_valid[s-1];
            pipe_err[s]   <= pipe_err[s-1];
            pipe_id[s]    <= pipe_id[s-1];
         end
      end
   end

   // Build the response record at the last pipe stage; illegal ops report 0.
   always_comb begin
      push              = pipe_valid[FPU_LAT-1];
      push_data         = '0;
      push_data.id[ID_W-1:0] = pipe_id[FPU_LAT-1];
      push_data.err     = pipe_err[FPU_LAT-1];
      push_data.result  = pipe_err[FPU_LAT-1] ? '0 : fpu_result_i;
   end

   assign pop = fifo_valid && rsp_ready_i;

   fpu_rsp_fifo #(
      .DEPTH (RSP_DEPTH)
   ) u_rsp_fifo (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .push_i      (push),
      .push_data_i (push_data),
      .pop_i       (pop),
      .valid_o     (fifo_valid),
      .head_o      (head),
      .count_o     (fifo_count)
   );

   // Response channel is forced to zero whenever the FIFO is empty.
   always_comb begin
      rsp_valid_o  = fifo_valid;
      rsp_id_o     = fifo_valid ? head.id[ID_W-1:0] : '0;
      rsp_result_o = fifo_valid ? head.result : '0;
      rsp_err_o    = fifo_valid && head.err;
      busy_o       = (|pipe_valid) || (fifo_count != '0);
   end

   // Upper id bits are always written as zero and never read back.
   assign unused_head_id = ^head.id;

endmodule

// File: tb/tb_fpu_sched.sv
// Self-checking bench for fpu_sched. A queue-based model predicts grants,
// FPU operands and responses every cycle; directed sections pin the model
// with hand-computed values, followed by a randomized traffic phase.
module tb_fpu_sched;
   import fpu_pkg::*;

   localparam int N_REQ     = 4;
   localparam int FPU_LAT   = 1;
   localparam int RSP_DEPTH = 4;
   localparam int ID_W      = 2;

   logic                  clk_i = 1'b0;
   logic                  rst_i;
   logic [N_REQ-1:0]      req_valid_i;
   logic [N_REQ-1:0]      req_ready_o;
   logic [3*N_REQ-1:0]    req_op_i;
   logic [32*N_REQ-1:0]   req_a_i;
   logic [32*N_REQ-1:0]   req_b_i;
   logic [31:0]           fpu_a_o;
   logic [31:0]           fpu_b_o;
   logic [2:0]            fpu_ctrl_o;
   logic [31:0]           fpu_result_i;
   logic                  rsp_valid_o;
   logic                  rsp_ready_i;
   logic [ID_W-1:0]       rsp_id_o;
   logic [31:0]           rsp_result_o;
   logic                  rsp_err_o;
   logic                  busy_o;

   int tests_run    = 0;
   int tests_failed = 0;
   int cyc          = 0;

   fpu_sched #(
      .N_REQ     (N_REQ),
      .FPU_LAT   (FPU_LAT),
      .RSP_DEPTH (RSP_DEPTH)
   ) dut (
      .clk_i        (clk_i),
      .rst_i        (rst_i),
      .req_valid_i  (req_valid_i),
      .req_ready_o  (req_ready_o),
      .req_op_i     (req_op_i),
      .req_a_i      (req_a_i),
      .req_b_i      (req_b_i),
      .fpu_a_o      (fpu_a_o),
      .fpu_b_o      (fpu_b_o),
      .fpu_ctrl_o   (fpu_ctrl_o),
      .fpu_result_i (fpu_result_i),
      .rsp_valid_o  (rsp_valid_o),
      .rsp_ready_i  (rsp_ready_i),
      .rsp_id_o     (rsp_id_o),
      .rsp_result_o (rsp_result_o),
      .rsp_err_o    (rsp_err_o),
      .busy_o       (busy_o)
   );

   always #5 clk_i = ~clk_i;

   always @(posedge clk_i) cyc <= cyc + 1;

   // ---------------- single-precision helpers (normal numbers only) -------
   function automatic real sp2r(input logic [31:0] x);
      logic [63:0] d;
      if (x[30:0] == 31'd0) return 0.0;
      d = {x[31], 11'(int'(x[30:23]) + 896), x[22:0], 29'd0};
      return $bitstoreal(d);
   endfunction

   function automatic logic [31:0] r2sp(input real r);
      logic [63:0] d;
      int          e;
      if (r == 0.0) return 32'd0;
      d = $realtobits(r);
      e = int'(d[62:52]) - 896;
      return {d[63], 8'(e), d[51:29]};
   endfunction

   // Stand-in FPU. The unimplemented opcode returns a non-zero pattern so
   // that the scheduler's zeroing of error responses is observable.
   function automatic logic [31:0] fpu_fn(input logic [2:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
      case (op)
         FP_ADD:  return r2sp(sp2r(a) + sp2r(b));
         FP_SUB:  return r2sp(sp2r(a) - sp2r(b));
         FP_MUL:  return r2sp(sp2r(a) * sp2r(b));
         FP_MAX:  return (sp2r(a) >= sp2r(b)) ? a : b;
         FP_MIN:  return (sp2r(a) <= sp2r(b)) ? a : b;
         FP_ABS:  return {1'b0, a[30:0]};
         FP_NEG:  return {~a[31], a[30:0]};
         default: return 32'hDEADBEEF;
      endcase
   endfunction

   always_comb fpu_result_i = fpu_fn(fpu_ctrl_o, fpu_a_o, fpu_b_o);

   function automatic logic [31:0] rand_fp();
      return {1'($urandom_range(0, 1)), 8'($urandom_range(100, 154)), 23'($urandom)};
   endfunction

   // ---------------- check / stimulus tasks --------------------------------
   task automatic check_output(input string name, input logic [63:0] act,
                               input logic [63:0] exp);
      tests_run++;
      if (act !== exp) begin
         tests_failed++;
         $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic set_req(input int i, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b);
      req_op_i[3*i +: 3]  = op;
      req_a_i[32*i +: 32] = a;
      req_b_i[32*i +: 32] = b;
   endtask

   task automatic randomize_reqs();
      for (int i = 0; i < N_REQ; i++) begin
         set_req(i, 3'($urandom_range(0, 6)), rand_fp(), rand_fp());
      end
   endtask

   task automatic next_cycle();
      @(posedge clk_i);
      #1;
   endtask

   task automatic apply_stimulus(input logic [N_REQ-1:0] valid, input logic ready);
      randomize_reqs();
      req_valid_i = valid;
      rsp_ready_i = ready;
   endtask

   task automatic drain();
      int n = 0;
      req_valid_i = '0;
      rsp_ready_i = 1'b1;
      while (n < 50) begin
         @(negedge clk_i);
         if (!busy_o) break;
         n++;
      end
      check_output("drain_busy", 64'(busy_o), 64'd0);
      next_cycle();
   endtask

   // ---------------- behavioural model + per-cycle compare ----------------
   typedef struct {
      int          id;
      logic [31:0] result;
      logic        err;
      int          rdy;
   } exp_t;

   exp_t        mq[$];
   int          mptr = 0;
   logic [31:0] exp_fa = '0;
   logic [31:0] exp_fb = '0;
   logic [2:0]  exp_fc = '0;

   always @(negedge clk_i) begin
      int               g;
      logic             found;
      logic             hs;
      logic [N_REQ-1:0] exp_ready;
      logic             vis;
      logic [2:0]       op;
      exp_t             e;
      if (rst_i) begin
         mq.delete();
         mptr   = 0;
         exp_fa = '0;
         exp_fb = '0;
         exp_fc = '0;
      end else begin
         found = 1'b0;
         g     = 0;
         for (int k = 0; k < N_REQ; k++) begin
            if (!found && req_valid_i[(mptr + k) % N_REQ]) begin
               found = 1'b1;
               g     = (mptr + k) % N_REQ;
            end
         end
         hs        = found && (mq.size() < RSP_DEPTH);
         exp_ready = '0;
         if (hs) exp_ready[g] = 1'b1;
         check_output("req_ready", 64'(req_ready_o), 64'(exp_ready));
         check_output("fpu_a", 64'(fpu_a_o), 64'(exp_fa));
         check_output("fpu_b", 64'(fpu_b_o), 64'(exp_fb));
         check_output("fpu_ctrl", 64'(fpu_ctrl_o), 64'(exp_fc));
         check_output("busy", 64'(busy_o), 64'(mq.size() != 0));
         vis = (mq.size() > 0) && (mq[0].rdy <= cyc);
         check_output("rsp_valid", 64'(rsp_valid_o), 64'(vis));
         if (vis) begin
            check_output("rsp_id", 64'(rsp_id_o), 64'(mq[0].id));
            check_output("rsp_result", 64'(rsp_result_o), 64'(mq[0].result));
            check_output("rsp_err", 64'(rsp_err_o), 64'(mq[0].err));
            if (rsp_ready_i) void'(mq.pop_front());
         end
         if (hs) begin
            op       = req_op_i[3*g +: 3];
            e.id     = g;
            e.err    = (op == 3'b111);
            e.result = e.err ? 32'd0 : fpu_fn(op, req_a_i[32*g +: 32], req_b_i[32*g +: 32]);
            e.rdy    = cyc + 1 + FPU_LAT;
            mq.push_back(e);
            exp_fa = req_a_i[32*g +: 32];
            exp_fb = req_b_i[32*g +: 32];
            exp_fc = op;
            mptr   = (g + 1) % N_REQ;
         end
      end
   end

   // ---------------- directed + random sequence ----------------------------
   initial begin
      int accepts;
      int seen2;
      logic [N_REQ-1:0] pending;

      rst_i       = 1'b1;
      req_valid_i = '0;
      rsp_ready_i = 1'b0;
      req_op_i    = '0;
      req_a_i     = '0;
      req_b_i     = '0;

      // Reset state
      next_cycle();
      check_output("reset_rsp_valid", 64'(rsp_valid_o), 64'd0);
      check_output("reset_busy", 64'(busy_o), 64'd0);
      check_output("reset_fpu_a", 64'(fpu_a_o), 64'd0);
      check_output("reset_rsp_result", 64'(rsp_result_o), 64'd0);
      next_cycle();
      rst_i = 1'b0;
      check_output("model_add_pin", 64'(fpu_fn(FP_ADD, 32'h3F800000, 32'h40000000)),
                   64'h40400000);

      // Single op: 1.0 + 2.0 from req0, response two cycles later
      set_req(0, FP_ADD, 32'h3F800000, 32'h40000000);
      req_valid_i = 4'b0001;
      rsp_ready_i = 1'b1;
      @(negedge clk_i);
      check_output("t1_ready", 64'(req_ready_o), 64'b0001);
      next_cycle();
      req_valid_i = '0;
      @(negedge clk_i);
      check_output("t1_no_early_rsp", 64'(rsp_valid_o), 64'd0);
      next_cycle();
      @(negedge clk_i);
      check_output("t1_rsp_valid", 64'(rsp_valid_o), 64'd1);
      check_output("t1_rsp_id", 64'(rsp_id_o), 64'd0);
      check_output("t1_rsp_result", 64'(rsp_result_o), 64'h40400000);
      next_cycle();

      // All requesters streaming: pointer sits at 1 after the req0 grant
      for (int k = 0; k < 12; k++) begin
         apply_stimulus(4'b1111, 1'b1);
         @(negedge clk_i);
         check_output("t2_rr_grant", 64'(req_ready_o), 64'(1 << ((1 + k) % 4)));
         next_cycle();
      end
      drain();

      // Back-pressure: credit allows exactly RSP_DEPTH accepts
      accepts = 0;
      for (int k = 0; k < 8; k++) begin
         apply_stimulus(4'b0001, 1'b0);
         @(negedge clk_i);
         accepts += int'(req_ready_o[0]);
         next_cycle();
      end
      check_output("t3_accepts", 64'(accepts), 64'(RSP_DEPTH));
      rsp_ready_i = 1'b1;
      @(negedge clk_i);
      check_output("t3_pop_cycle_ready", 64'(req_ready_o[0]), 64'd0);
      next_cycle();
      rsp_ready_i = 1'b0;
      @(negedge clk_i);
      check_output("t3_after_pop_ready", 64'(req_ready_o[0]), 64'd1);
      next_cycle();
      @(negedge clk_i);
      check_output("t3_full_again", 64'(req_ready_o[0]), 64'd0);
      next_cycle();
      drain();

      // Illegal opcode on req2 between two legal neighbours
      set_req(1, FP_ADD, rand_fp(), rand_fp());
      set_req(2, 3'b111, rand_fp(), rand_fp());
      set_req(3, FP_MUL, rand_fp(), rand_fp());
      pending     = 4'b1110;
      req_valid_i = pending;
      rsp_ready_i = 1'b1;
      seen2       = 0;
      for (int k = 0; k < 12; k++) begin
         @(negedge clk_i);
         if (rsp_valid_o) begin
            if (rsp_id_o == 2'd2) begin
               seen2++;
               check_output("t4_err", 64'(rsp_err_o), 64'd1);
               check_output("t4_err_result", 64'(rsp_result_o), 64'd0);
            end else begin
               check_output("t4_neighbour_err", 64'(rsp_err_o), 64'd0);
            end
         end
         pending = pending & ~req_ready_o;
         next_cycle();
         req_valid_i = pending;
      end
      check_output("t4_seen_id2", 64'(seen2), 64'd1);
      drain();

      // Asynchronous reset with 3 queued and 1 in flight
      accepts = 0;
      for (int k = 0; k < 10 && accepts < 4; k++) begin
         apply_stimulus(4'b0001, 1'b0);
         @(negedge clk_i);
         accepts += int'(req_ready_o[0]);
         next_cycle();
      end
      check_output("t5_accepts", 64'(accepts), 64'd4);
      req_valid_i = '0;
      check_output("t5_pre_rsp_valid", 64'(rsp_valid_o), 64'd1);
      check_output("t5_pre_busy", 64'(busy_o), 64'd1);
      #1 rst_i = 1'b1;
      #1;
      check_output("t5_rst_rsp_valid", 64'(rsp_valid_o), 64'd0);
      check_output("t5_rst_busy", 64'(busy_o), 64'd0);
      check_output("t5_rst_fpu_a", 64'(fpu_a_o), 64'd0);
      check_output("t5_rst_fpu_b", 64'(fpu_b_o), 64'd0);
      check_output("t5_rst_fpu_ctrl", 64'(fpu_ctrl_o), 64'd0);
      next_cycle();
      rst_i = 1'b0;
      apply_stimulus(4'b1111, 1'b1);
      @(negedge clk_i);
      check_output("t5_first_grant", 64'(req_ready_o), 64'b0001);
      next_cycle();

      // Pointer wrap: req1 alone, then req3 and req0 together
      apply_stimulus(4'b0010, 1'b1);
      @(negedge clk_i);
      check_output("t6_grant_1", 64'(req_ready_o), 64'b0010);
      next_cycle();
      apply_stimulus(4'b1001, 1'b1);
      @(negedge clk_i);
      check_output("t6_grant_3", 64'(req_ready_o), 64'b1000);
      next_cycle();
      req_valid_i = 4'b0001;
      @(negedge clk_i);
      check_output("t6_grant_0", 64'(req_ready_o), 64'b0001);
      next_cycle();
      drain();

      // Randomized traffic with random back-pressure
      for (int k = 0; k < 600; k++) begin
         apply_stimulus(4'($urandom), ($urandom_range(0, 3) != 0));
         if ((k / 50) % 3 == 2) rsp_ready_i = ($urandom_range(0, 4) == 0);
         next_cycle();
      end
      drain();

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

   // Watchdog so the run can never hang
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
